// File: rtl/dmem_wait_bank_if.sv
// dmem_wait_bank_if: request/response bundle between the datapath MEM stage
// (master) and the data-memory bank (slave).
//   req/we/size/unsigned_ld/addr/wdata : request fields, driven by the master
//   ready/done/rdata/err/init_busy     : handshake and response, driven by the bank
interface dmem_wait_bank_if #(
  parameter int ADDR_W = 9
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              unsigned_ld;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              ready;
  logic              done;
  logic [31:0]       rdata;
  logic              err;
  logic              init_busy;

  modport master (
    output req, we, size, unsigned_ld, addr, wdata,
    input  ready, done, rdata, err, init_busy
  );

  modport slave (
    input  req, we, size, unsigned_ld, addr, wdata,
    output ready, done, rdata, err, init_busy
  );
endinterface

// File: rtl/dmem_wait_bank.sv
// dmem_wait_bank: clocked data-memory bank with a request/ready handshake,
// WAIT wait states per access, byte/half/word loads and stores with sign or
// zero extension, alignment checking and a power-up fill of word i with
// i*INIT_STEP.
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset (cancels any in-flight access, reruns init)
//   bus : slave side of dmem_wait_bank_if (request fields in, ready/done/rdata/err/init_busy out)
module dmem_wait_bank #(
  parameter int DEPTH     = 128,
  parameter int WAIT      = 2,
  parameter int INIT_STEP = 10,
  parameter int ADDR_W    = $clog2(DEPTH) + 2
) (
  input logic             clk,
  input logic             rst,
  dmem_wait_bank_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  // The counter is loaded with WAIT-1 so the access happens on the cycle it reads 0.
  localparam logic [3:0]       WAIT_LD  = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  // Rejects illegal sizes and accesses not aligned to their own width.
  function automatic logic misaligned(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b1;
    endcase
  endfunction

  // Little-endian lane/half extraction followed by sign or zero extension.
  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] sz,
                                               input logic [1:0] lane, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (sz)
      2'b00:   load_extract = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   load_extract = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   load_extract = word;
      default: load_extract = 32'h0000_0000;
    endcase
  endfunction

  // Read-modify-write merge: only the addressed lanes take new data.
  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] lane);
    store_merge = word;
    case (sz)
      2'b00:   store_merge[{lane, 3'b000} +: 8] = wd[7:0];
      2'b01:   store_merge[{lane[1], 4'b0000} +: 16] = wd[15:0];
      2'b10:   store_merge = wd;
      default: store_merge = word;
    endcase
  endfunction

  logic [31:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [3:0]        wcnt_q, wcnt_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              init_busy_q, init_busy_d;

  logic              cur_we;
  logic [1:0]        cur_size;
  logic              cur_uns;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [IDX_W-1:0]  cur_idx;
  logic [31:0]       rd_word;
  logic              access;
  logic              bad;
  logic              mem_we;
  logic [IDX_W-1:0]  mem_widx;
  logic [31:0]       mem_wdata;

  assign cur_idx = cur_addr[ADDR_W-1:2];
  assign rd_word = mem[cur_idx];

  assign bus.ready     = ready_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rdata     = rdata_q;
  assign bus.init_busy = init_busy_q;

  // Next-state, request capture, access execution and registered-output logic.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    wcnt_d    = wcnt_q;
    we_d      = we_q;
    size_d    = size_q;
    uns_d     = uns_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    rdata_d   = rdata_q;
    mem_we    = 1'b0;
    mem_widx  = idx_q;
    mem_wdata = 32'h0000_0000;
    access    = 1'b0;
    bad       = 1'b0;

    // With WAIT=0 the access runs straight off the bus in the accept cycle.
    if (state_q == S_IDLE) begin
      cur_we = bus.we; cur_size = bus.size; cur_uns = bus.unsigned_ld;
      cur_addr = bus.addr; cur_wdata = bus.wdata;
    end else begin
      cur_we = we_q; cur_size = size_q; cur_uns = uns_q;
      cur_addr = addr_q; cur_wdata = wdata_q;
    end

    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_widx  = idx_q;
        mem_wdata = 32'(idx_q) * 32'(INIT_STEP);
        idx_d     = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INIT;
        end
      end
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          size_d  = bus.size;
          uns_d   = bus.unsigned_ld;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          wcnt_d  = WAIT_LD;
          if (WAIT == 0) begin
            access  = 1'b1;
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (wcnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_RESP;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_INIT;
        idx_d   = '0;
      end
    endcase

    if (access) begin
      bad    = misaligned(cur_size, cur_addr[1:0]);
      done_d = 1'b1;
      err_d  = bad;
      if (!cur_we && !bad) begin
        rdata_d = load_extract(rd_word, cur_size, cur_addr[1:0], cur_uns);
      end else begin
        rdata_d = 32'h0000_0000;
      end
      if (cur_we && !bad) begin
        mem_we    = 1'b1;
        mem_widx  = cur_idx;
        mem_wdata = store_merge(rd_word, cur_wdata, cur_size, cur_addr[1:0]);
      end else begin
        mem_we = mem_we;
      end
    end else begin
      rdata_d = rdata_q;
    end

    ready_d     = (state_d == S_IDLE);
    init_busy_d = (state_d == S_INIT);
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_INIT;
      idx_q       <= '0;
      wcnt_q      <= 4'd0;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0000_0000;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= 32'h0000_0000;
      init_busy_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      wcnt_q      <= wcnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      init_busy_q <= init_busy_d;
    end
  end

  // Word array write port; a store landing on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[mem_widx] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_dmem_wait_bank.sv
// tb_dmem_wait_bank: two banks (WAIT=2 and WAIT=0, DEPTH=128, INIT_STEP=10)
// driven with directed and random accesses; a cycle-timed behavioural model
// predicts every output each cycle, and directed literals pin the model.
module tb_dmem_wait_bank;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic        req_a [2];
  logic        we_a  [2];
  logic [1:0]  size_a[2];
  logic        uns_a [2];
  logic [8:0]  addr_a[2];
  logic [31:0] wd_a  [2];
  logic        ready_a[2];
  logic        done_a [2];
  logic        err_a  [2];
  logic        busy_a [2];
  logic [31:0] rdata_a[2];

  dmem_wait_bank_if #(.ADDR_W(9)) b0 ();
  dmem_wait_bank_if #(.ADDR_W(9)) b1 ();

  assign b0.req = req_a[0]; assign b0.we = we_a[0]; assign b0.size = size_a[0];
  assign b0.unsigned_ld = uns_a[0]; assign b0.addr = addr_a[0]; assign b0.wdata = wd_a[0];
  assign b1.req = req_a[1]; assign b1.we = we_a[1]; assign b1.size = size_a[1];
  assign b1.unsigned_ld = uns_a[1]; assign b1.addr = addr_a[1]; assign b1.wdata = wd_a[1];
  assign ready_a[0] = b0.ready; assign done_a[0] = b0.done; assign err_a[0] = b0.err;
  assign busy_a[0] = b0.init_busy; assign rdata_a[0] = b0.rdata;
  assign ready_a[1] = b1.ready; assign done_a[1] = b1.done; assign err_a[1] = b1.err;
  assign busy_a[1] = b1.init_busy; assign rdata_a[1] = b1.rdata;

  dmem_wait_bank #(.DEPTH(128), .WAIT(2), .INIT_STEP(10), .ADDR_W(9)) u_dut0 (
    .clk(clk), .rst(rst), .bus(b0));
  dmem_wait_bank #(.DEPTH(128), .WAIT(0), .INIT_STEP(10), .ADDR_W(9)) u_dut1 (
    .clk(clk), .rst(rst), .bus(b1));

  // ---------------- behavioural model (time-based, per bank) ----------------
  logic [31:0] mdl_mem [2][128];
  bit          valid [2] = '{1'b0, 1'b0};
  longint      init_end [2], next_free [2], p_done [2], p_commit [2];
  bit          pv [2], p_store [2], p_err [2];
  logic [31:0] p_rdata [2], p_wword [2], hold [2];
  int          p_widx [2];

  function automatic int wait_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic bit exp_ready(input int d);
    return valid[d] && (cyc >= init_end[d]) && (cyc >= next_free[d]);
  endfunction

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc %0d: got %h, expected %h", nm, d, cyc, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: no response within bound at cyc %0d", nm, cyc);
  endtask

  // Work out the result of one access from byte-level arithmetic.
  task automatic mdl_access(input int d, input logic w, input logic [1:0] sz, input logic u,
                            input logic [8:0] a, input logic [31:0] wd);
    int     nb, lane;
    longint word, mask, val, nw;
    bit     bad;
    lane = int'(a) % 4;
    nb   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
    bad  = (nb == 0) ? 1'b1 : ((lane % nb) != 0);
    word = longint'({32'h0, mdl_mem[d][int'(a) / 4]});
    mask = (nb == 0) ? 64'd0 : ((64'd1 << (8 * nb)) - 64'd1);
    p_err[d]   = bad;
    p_store[d] = w && !bad;
    p_widx[d]  = int'(a) / 4;
    p_rdata[d] = 32'h0;
    if (!w && !bad) begin
      val = (word >> (8 * lane)) & mask;
      if (!u && val >= (mask + 1) / 2) val = val - (mask + 1);
      p_rdata[d] = val[31:0];
    end
    nw = (word & ~(mask << (8 * lane))) | ((longint'({32'h0, wd}) & mask) << (8 * lane));
    p_wword[d] = nw[31:0];
  endtask

  task automatic mdl_step(input int d);
    int w;
    w = wait_of(d);
    if (rst) begin
      for (int i = 0; i < 128; i++) mdl_mem[d][i] = 32'(i * 10);
      init_end[d]  = cyc + 1 + 128;
      next_free[d] = init_end[d];
      pv[d]        = 1'b0;
      hold[d]      = 32'h0;
      valid[d]     = 1'b1;
    end else if (valid[d]) begin
      if (pv[d] && cyc == p_done[d]) begin
        hold[d] = p_rdata[d];
        pv[d]   = 1'b0;
      end
      if (exp_ready(d) && req_a[d]) begin
        mdl_access(d, we_a[d], size_a[d], uns_a[d], addr_a[d], wd_a[d]);
        pv[d]        = 1'b1;
        p_commit[d]  = cyc + w;
        p_done[d]    = cyc + w + 1;
        next_free[d] = cyc + w + 2;
      end
      if (pv[d] && p_store[d] && cyc == p_commit[d]) mdl_mem[d][p_widx[d]] = p_wword[d];
    end
  endtask

  // Every cycle: compare both banks against the model, then advance it.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (valid[d]) begin
        bit ed;
        ed = pv[d] && (cyc == p_done[d]);
        chk("ready", d, {31'b0, ready_a[d]}, {31'b0, exp_ready(d)});
        chk("init_busy", d, {31'b0, busy_a[d]}, {31'b0, (cyc < init_end[d])});
        chk("done", d, {31'b0, done_a[d]}, {31'b0, ed});
        chk("err", d, {31'b0, err_a[d]}, {31'b0, ed && p_err[d]});
        chk("rdata", d, rdata_a[d], ed ? p_rdata[d] : hold[d]);
      end
      mdl_step(d);
    end
  end

  // ---------------- stimulus ----------------
  task automatic do_op(input int d, input logic w, input logic [1:0] sz, input logic u,
                       input logic [8:0] a, input logic [31:0] wd,
                       output logic [31:0] rd, output logic e, output int lat);
    longint t;
    bit     got;
    rd = 32'h0; e = 1'b0; lat = -1; t = 0;
    @(posedge clk); #1;
    req_a[d] = 1'b1; we_a[d] = w; size_a[d] = sz; uns_a[d] = u; addr_a[d] = a; wd_a[d] = wd;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (ready_a[d]) begin got = 1'b1; t = cyc; end
    end
    @(posedge clk); #1;
    req_a[d] = 1'b0;
    if (!got) begin tmo("accept"); return; end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (done_a[d]) begin got = 1'b1; rd = rdata_a[d]; e = err_a[d]; lat = int'(cyc - t); end
    end
    if (!got) tmo("done");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat, cnt, nd;
    longint      dq[$];
    for (int d = 0; d < 2; d++) begin
      req_a[d] = 1'b0; we_a[d] = 1'b0; size_a[d] = 2'd0; uns_a[d] = 1'b0;
      addr_a[d] = 9'd0; wd_a[d] = 32'h0;
    end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    cnt = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (busy_a[0]) cnt++;
      if (ready_a[0]) break;
    end
    chk("init_busy_cycles", 0, 32'(cnt), 32'd128);

    // Init contents and latency on the WAIT=2 bank.
    do_op(0, 1'b0, 2'd2, 1'b0, 9'd0, 32'h0, rd, e, lat);
    chk("init_w0", 0, rd, 32'd0);
    chk("latency_w2", 0, 32'(lat), 32'd3);
    do_op(0, 1'b0, 2'd2, 1'b0, 9'd4, 32'h0, rd, e, lat);
    chk("init_w4", 0, rd, 32'd10);
    do_op(0, 1'b0, 2'd2, 1'b0, 9'd508, 32'h0, rd, e, lat);
    chk("init_w508", 0, rd, 32'd1270);

    // Extension cases.
    do_op(0, 1'b1, 2'd2, 1'b0, 9'd8, 32'h80F1_7F01, rd, e, lat);
    chk("store_rdata", 0, rd, 32'h0);
    chk("store_err", 0, {31'b0, e}, 32'd0);
    do_op(0, 1'b0, 2'd0, 1'b0, 9'd9, 32'h0, rd, e, lat);
    chk("lb9_s", 0, rd, 32'h0000_007F);
    do_op(0, 1'b0, 2'd0, 1'b0, 9'd11, 32'h0, rd, e, lat);
    chk("lb11_s", 0, rd, 32'hFFFF_FF80);
    do_op(0, 1'b0, 2'd0, 1'b1, 9'd11, 32'h0, rd, e, lat);
    chk("lb11_u", 0, rd, 32'h0000_0080);
    do_op(0, 1'b0, 2'd1, 1'b0, 9'd10, 32'h0, rd, e, lat);
    chk("lh10_s", 0, rd, 32'hFFFF_80F1);

    // Byte merge into init word 30.
    do_op(0, 1'b1, 2'd0, 1'b0, 9'd13, 32'h0000_00AB, rd, e, lat);
    do_op(0, 1'b0, 2'd2, 1'b0, 9'd12, 32'h0, rd, e, lat);
    chk("byte_merge", 0, rd, 32'h0000_AB1E);

    // Misaligned / illegal accesses: error, zero data, same latency, no write.
    do_op(0, 1'b1, 2'd2, 1'b0, 9'd2, 32'hFFFF_FFFF, rd, e, lat);
    chk("mis_w2_err", 0, {31'b0, e}, 32'd1);
    chk("mis_w2_rdata", 0, rd, 32'h0);
    chk("mis_w2_lat", 0, 32'(lat), 32'd3);
    do_op(0, 1'b1, 2'd1, 1'b0, 9'd1, 32'hFFFF_FFFF, rd, e, lat);
    chk("mis_h1_err", 0, {31'b0, e}, 32'd1);
    do_op(0, 1'b0, 2'd2, 1'b0, 9'd0, 32'h0, rd, e, lat);
    chk("mis_w0_unchanged", 0, rd, 32'd0);
    do_op(0, 1'b1, 2'd3, 1'b0, 9'd4, 32'hFFFF_FFFF, rd, e, lat);
    chk("size11_err", 0, {31'b0, e}, 32'd1);
    chk("size11_rdata", 0, rd, 32'h0);
    do_op(0, 1'b0, 2'd2, 1'b0, 9'd4, 32'h0, rd, e, lat);
    chk("size11_unchanged", 0, rd, 32'd10);
    do_op(0, 1'b0, 2'd2, 1'b0, 9'd6, 32'h0, rd, e, lat);
    chk("mis_load_err", 0, {31'b0, e}, 32'd1);

    // req held high: one accept every WAIT+2 cycles.
    @(posedge clk); #1;
    req_a[0] = 1'b1; we_a[0] = 1'b0; size_a[0] = 2'd2; uns_a[0] = 1'b0; addr_a[0] = 9'd0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      if (done_a[0]) dq.push_back(cyc);
    end
    @(posedge clk); #1 req_a[0] = 1'b0;
    repeat (6) @(posedge clk);
    chk("b2b_count", 0, 32'(dq.size()), 32'd3);
    if (dq.size() >= 3) begin
      chk("b2b_gap1", 0, 32'(dq[1] - dq[0]), 32'd4);
      chk("b2b_gap2", 0, 32'(dq[2] - dq[1]), 32'd4);
    end

    // WAIT=0 bank.
    do_op(1, 1'b0, 2'd2, 1'b0, 9'd4, 32'h0, rd, e, lat);
    chk("w0_init_w4", 1, rd, 32'd10);
    chk("latency_w0", 1, 32'(lat), 32'd1);
    do_op(1, 1'b1, 2'd2, 1'b0, 9'd16, 32'h1234_5678, rd, e, lat);
    do_op(1, 1'b0, 2'd2, 1'b0, 9'd16, 32'h0, rd, e, lat);
    chk("w0_store_load", 1, rd, 32'h1234_5678);

    // Random traffic on both banks; the model checks every cycle.
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 150; k++) begin
        logic [1:0]  sz;
        logic [8:0]  a;
        int          r;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        r  = int'($urandom_range(0, 9));
        sz = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
        a  = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 63)) : 9'($urandom_range(0, 511));
        if ($urandom_range(0, 4) != 0) begin
          if (sz == 2'd1) a[0] = 1'b0;
          if (sz == 2'd2) a[1:0] = 2'b00;
        end
        do_op(d, 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd, e, lat);
      end
    end

    // Reset in the middle of a store on the WAIT=2 bank.
    @(posedge clk); #1;
    req_a[0] = 1'b1; we_a[0] = 1'b1; size_a[0] = 2'd2; addr_a[0] = 9'd0; wd_a[0] = 32'hDEAD_BEEF;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (ready_a[0]) begin cnt = 1; break; end
    end
    if (cnt == 0) tmo("rst_store_accept");
    @(posedge clk); #1;
    req_a[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nd = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done_a[0]) nd++;
    end
    chk("rst_no_done", 0, 32'(nd), 32'd0);
    do_op(0, 1'b0, 2'd2, 1'b0, 9'd0, 32'h0, rd, e, lat);
    chk("rst_store_dropped", 0, rd, 32'd0);

    repeat (5) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
